// File: rtl/gigatron_kbd_pkg.sv
// rtl/gigatron_kbd_pkg.sv - shared types, scancode constants and lookups for the Gigatron PS/2 pad
// Purpose : receiver state enum, inreg button bit indices, PS/2 set-2 scancode constants,
//           button lookup (ext, code) -> bit index and scancode -> ASCII lookup (0 = none).
// Ports   : none (package).
package gigatron_kbd_pkg;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_X     = 8'h22;
   localparam logic [7:0] SC_Z     = 8'h1A;

   // Returns {hit, bit_index}; arrows only match with the E0 prefix, the rest only without it.
   function automatic logic [3:0] btn_lookup(input logic ext, input logic [7:0] code);
      logic [3:0] r;
      r = 4'b0000;
      if (ext) begin
         case (code)
            SC_RIGHT: r = {1'b1, 3'(BTN_RIGHT)};
            SC_LEFT:  r = {1'b1, 3'(BTN_LEFT)};
            SC_DOWN:  r = {1'b1, 3'(BTN_DOWN)};
            SC_UP:    r = {1'b1, 3'(BTN_UP)};
            default:  r = 4'b0000;
         endcase
      end else begin
         case (code)
            SC_ENTER: r = {1'b1, 3'(BTN_START)};
            SC_ESC:   r = {1'b1, 3'(BTN_SELECT)};
            SC_X:     r = {1'b1, 3'(BTN_B)};
            SC_Z:     r = {1'b1, 3'(BTN_A)};
            default:  r = 4'b0000;
         endcase
      end
      return r;
   endfunction

   function automatic logic [7:0] ascii_of(input logic [7:0] code);
      case (code)
         8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
         8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
         8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
         8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
         8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
         8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
         8'h35: return 8'h79; 8'h1A: return 8'h7A;
         8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
         8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
         8'h3E: return 8'h38; 8'h46: return 8'h39;
         8'h29: return 8'h20;
         8'h5A: return 8'h0A;
         8'h66: return 8'h7F;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/gigatron_ps2_pad_if.sv
// rtl/gigatron_ps2_pad_if.sv - pin and inreg/scancode bundle of the Gigatron PS/2 pad
// Purpose : groups the raw PS/2 pins and the decoded outputs.
// Ports   : slave  = pad side (reads pins, drives inreg/scan_*/frame_err)
//           master = board/CPU side (drives pins, reads results)
interface gigatron_ps2_pad_if;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [7:0] inreg;
   logic       scan_valid;
   logic [7:0] scan_code;
   logic       scan_ext;
   logic       scan_release;
   logic       frame_err;

   modport slave (
      input  ps2_clk, ps2_dat,
      output inreg, scan_valid, scan_code, scan_ext, scan_release, frame_err
   );

   modport master (
      output ps2_clk, ps2_dat,
      input  inreg, scan_valid, scan_code, scan_ext, scan_release, frame_err
   );
endinterface

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver
// Purpose : synchronises both pins, deglitches ps2_clk, shifts 11-bit frames on filtered
//           falling edges, checks parity/stop and aborts stalled frames.
// Ports   : clock, rst (async, active-high); ps2_clk, ps2_dat raw pins;
//           rx_byte / rx_valid (one-cycle) on a good frame; rx_err (one-cycle) on a bad or stalled frame.
module ps2_rx_frame
   import gigatron_kbd_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 12500
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          filt_q, filt_d;
   rx_state_e     state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d, err_q, err_d;
   logic          fall, dat;

   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_dat};
      dat        = dat_sync_q[1];

      // Level is only accepted after FILTER_LEN consecutive samples disagree with it.
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
         else                                   filt_cnt_d = filt_cnt_q + 1'b1;
      end
      fall = filt_q & ~filt_d;

      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      tmo_d     = '0;

      case (state_q)
         RX_IDLE: begin
            if (fall && !dat) begin
               state_d   = RX_DATA;
               bit_cnt_d = '0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shift_d   = {dat, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (fall) begin
               par_d   = dat;
               state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               if (dat && (^{shift_q, par_q})) begin
                  valid_d = 1'b1;
                  byte_d  = shift_q;
               end else begin
                  err_d = 1'b1;
               end
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase

      // Stall watchdog: any non-idle state must see a falling edge within TIMEOUT_CYC clocks.
      if (state_q != RX_IDLE && !fall) begin
         if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = RX_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_cnt_q <= '0;
         filt_q     <= 1'b1;
         state_q    <= RX_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tmo_q      <= '0;
         byte_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_cnt_q <= filt_cnt_d;
         filt_q     <= filt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign rx_byte  = byte_q;
   assign rx_valid = valid_q;
   assign rx_err   = err_q;
endmodule

// File: rtl/gigatron_ps2_pad.sv
// rtl/gigatron_ps2_pad.sv - PS/2 keyboard to Gigatron inreg front-end
// Purpose : decodes E0/F0 prefixed scancodes into an active-low button vector driving inreg.
//           Optional macro GIGA_KBD_ASCII_EN: ASCII make codes override inreg for ASCII_HOLD clocks.
// Ports   : clock, rst (async, active-high); bus (slave): ps2_clk/ps2_dat in,
//           inreg, scan_valid, scan_code, scan_ext, scan_release, frame_err out.
module gigatron_ps2_pad
   import gigatron_kbd_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 12500,
   parameter int ASCII_HOLD  = 208333
) (
   input  logic               clock,
   input  logic               rst,
   gigatron_ps2_pad_if.slave  bus
);
   logic [7:0] rx_byte;
   logic       rx_valid, rx_err;

   ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clock    (clock),
      .rst      (rst),
      .ps2_clk  (bus.ps2_clk),
      .ps2_dat  (bus.ps2_dat),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   logic       ext_q, ext_d, rel_q, rel_d;
   logic [7:0] btn_q, btn_d, code_q, code_d;
   logic       sv_q, sv_d, sext_q, sext_d, srel_q, srel_d, ferr_q, ferr_d;
   logic [3:0] hit;
   logic       is_prefix;

   always_comb begin
      ext_d     = ext_q;
      rel_d     = rel_q;
      btn_d     = btn_q;
      code_d    = code_q;
      sext_d    = sext_q;
      srel_d    = srel_q;
      sv_d      = 1'b0;
      ferr_d    = rx_err;
      is_prefix = (rx_byte == SC_E0) || (rx_byte == SC_F0);
      hit       = btn_lookup(ext_q, rx_byte);
      if (rx_err) begin
         ext_d = 1'b0;
         rel_d = 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == SC_E0) begin
            ext_d = 1'b1;
         end else if (rx_byte == SC_F0) begin
            rel_d = 1'b1;
         end else begin
            sv_d   = 1'b1;
            code_d = rx_byte;
            sext_d = ext_q;
            srel_d = rel_q;
            // Active-low: make clears the bit, break sets it.
            if (hit[3]) btn_d[hit[2:0]] = rel_q;
            ext_d = 1'b0;
            rel_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         ext_q  <= 1'b0;
         rel_q  <= 1'b0;
         btn_q  <= 8'hFF;
         code_q <= '0;
         sext_q <= 1'b0;
         srel_q <= 1'b0;
         sv_q   <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ext_q  <= ext_d;
         rel_q  <= rel_d;
         btn_q  <= btn_d;
         code_q <= code_d;
         sext_q <= sext_d;
         srel_q <= srel_d;
         sv_q   <= sv_d;
         ferr_q <= ferr_d;
      end
   end

`ifdef GIGA_KBD_ASCII_EN
   localparam int HW = $clog2(ASCII_HOLD + 1);
   logic [HW-1:0] hold_q, hold_d;
   logic [7:0]    ascii_q, ascii_d, ascii_lu;

   always_comb begin
      hold_d   = hold_q;
      ascii_d  = ascii_q;
      ascii_lu = ascii_of(rx_byte);
      if (hold_q != '0) hold_d = hold_q - 1'b1;
      // Only plain makes produce ASCII; a new one reloads and restarts the hold.
      if (rx_valid && !is_prefix && !ext_q && !rel_q && ascii_lu != 8'h00) begin
         ascii_d = ascii_lu;
         hold_d  = HW'(ASCII_HOLD);
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         hold_q  <= '0;
         ascii_q <= '0;
      end else begin
         hold_q  <= hold_d;
         ascii_q <= ascii_d;
      end
   end

   assign bus.inreg = (hold_q != '0) ? ascii_q : btn_q;
`else
   localparam int unused_ascii_hold = ASCII_HOLD;
   logic unused_prefix;
   assign unused_prefix = is_prefix;
   assign bus.inreg = btn_q;
`endif

   assign bus.scan_valid   = sv_q;
   assign bus.scan_code    = code_q;
   assign bus.scan_ext     = sext_q;
   assign bus.scan_release = srel_q;
   assign bus.frame_err    = ferr_q;
endmodule
